// File: rtl/stream_packet_mux.sv
// ============================================================================
// Module      : stream_packet_mux
// Description : Packet-atomic 2:1 stream mux. Port 2 (control) has fixed
//               priority at packet start; one registered output stage.
//               Optional sticky error flag when STREAM_PACKET_MUX_ERR_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_packet_mux #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  sink_valid,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  output logic                  sink_ready,
  input  logic [DATA_WIDTH-1:0] sink_data2,
  input  logic                  sink_valid2,
  input  logic                  sink_sop2,
  input  logic                  sink_eop2,
  output logic                  sink_ready2,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic                  source_valid,
  output logic                  source_sop,
  output logic                  source_eop,
  input  logic                  source_ready
`ifdef STREAM_PACKET_MUX_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK1 = 2'd1;
  localparam logic [1:0] S_LOCK2 = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_can_accept;
  logic                  w_win2;
  logic                  w_rdy1;
  logic                  w_rdy2;
  logic                  w_fwd1;
  logic                  w_fwd2;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;

  assign w_can_accept = !r_valid || source_ready;
  assign w_win2       = sink_valid2 && sink_sop2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fwd2 && !sink_eop2) begin
          w_state_nxt = S_LOCK2;
        end else if (w_fwd1 && !sink_eop) begin
          w_state_nxt = S_LOCK1;
        end
      end
      S_LOCK1: if (w_fwd1 && sink_eop)  w_state_nxt = S_IDLE;
      S_LOCK2: if (w_fwd2 && sink_eop2) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In IDLE, beats without sop are always consumed so stray tails drain away.
  always_comb begin
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    w_fwd1 = 1'b0;
    w_fwd2 = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy2 = !sink_sop2 || w_can_accept;
        w_rdy1 = !sink_sop  || (!w_win2 && w_can_accept);
        w_fwd2 = w_win2 && w_can_accept;
        w_fwd1 = sink_valid && sink_sop && !w_win2 && w_can_accept;
      end
      S_LOCK1: begin
        w_rdy1 = w_can_accept;
        w_fwd1 = sink_valid && w_can_accept;
      end
      S_LOCK2: begin
        w_rdy2 = w_can_accept;
        w_fwd2 = sink_valid2 && w_can_accept;
      end
      default: begin
        w_rdy1 = 1'b0;
        w_rdy2 = 1'b0;
      end
    endcase
  end

  assign sink_ready  = reset_n && w_rdy1;
  assign sink_ready2 = reset_n && w_rdy2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (w_fwd2) begin
      r_data  <= sink_data2;
      r_valid <= 1'b1;
      r_sop   <= sink_sop2;
      r_eop   <= sink_eop2;
    end else if (w_fwd1) begin
      r_data  <= sink_data;
      r_valid <= 1'b1;
      r_sop   <= sink_sop;
      r_eop   <= sink_eop;
    end else if (source_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign source_data  = r_data;
  assign source_valid = r_valid;
  assign source_sop   = r_sop;
  assign source_eop   = r_eop;

`ifdef STREAM_PACKET_MUX_ERR_EN
  logic w_err_evt;
  logic r_err;

  // Flags a dropped headless beat, or a new sop arriving inside a packet.
  assign w_err_evt = ((r_state == S_IDLE) &&
                      ((sink_valid && !sink_sop) || (sink_valid2 && !sink_sop2))) ||
                     ((r_state == S_LOCK1) && w_fwd1 && sink_sop) ||
                     ((r_state == S_LOCK2) && w_fwd2 && sink_sop2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: doc/stream_packet_mux.md
STREAM_PACKET_MUX -- requirements
Module: stream_packet_mux

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the payload width in bits (3x8 RGB).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports sink_data/sink_valid/sink_sop/sink_eop, inputs, DATA_WIDTH/1/1/1: video packet stream (port 1).
REQ-005 The block SHALL have port sink_ready, output, 1: port 1 ready.
REQ-006 The block SHALL have ports sink_data2/sink_valid2/sink_sop2/sink_eop2, inputs, DATA_WIDTH/1/1/1: control packet stream (port 2).
REQ-007 The block SHALL have port sink_ready2, output, 1: port 2 ready.
REQ-008 The block SHALL have ports source_data/source_valid/source_sop/source_eop, outputs, DATA_WIDTH/1/1/1: merged stream.
REQ-009 The block SHALL have port source_ready, input, 1: downstream ready.
REQ-010 The block SHALL have port err, output, 1: sticky protocol-error flag, present only when STREAM_PACKET_MUX_ERR_EN is defined.

Function
REQ-011 The block SHALL merge the two sink streams into one source stream and SHALL never interleave beats of different packets.
REQ-012 The arbiter SHALL have states IDLE, LOCK1 (port 1 granted) and LOCK2 (port 2 granted).
REQ-013 In IDLE, sink_valid2 & sink_sop2 SHALL win over sink_valid & sink_sop, so control packets have fixed priority.
REQ-014 In IDLE, the winning sop beat SHALL be accepted in the same cycle it wins, provided the output register can accept.
REQ-015 On acceptance of a winning sop beat without eop, the arbiter SHALL move to LOCK1 or LOCK2 as appropriate.
REQ-016 A single-beat packet (sop & eop) SHALL be forwarded with the arbiter remaining in IDLE.
REQ-017 In IDLE, a valid beat without sop SHALL be consumed (ready=1) and dropped, never forwarded.
REQ-018 In LOCKn, only port n SHALL see ready; the other port's ready SHALL be 0.
REQ-019 In LOCKn, acceptance of a beat with eop SHALL return the arbiter to IDLE next cycle.
REQ-020 In LOCKn, a beat with sop but no eop SHALL be forwarded unchanged, and the grant SHALL be retained.
REQ-021 The output register SHALL be a single pipeline stage.
REQ-022 The output register's can-accept condition SHALL be !source_valid | source_ready.
REQ-023 A granted sink's ready SHALL equal the output register's can-accept condition.
REQ-024 Latency SHALL be 1 cycle: a beat accepted at edge k appears on source at k, valid from cycle k+1.
REQ-025 Throughput SHALL be 1 beat/cycle while source_ready=1.
REQ-026 While source_valid=1 & source_ready=0, source_data/sop/eop SHALL hold stable.
REQ-027 Data, sop and eop SHALL pass bit-exact, with no arithmetic.
REQ-028 When both ports present sop in the same cycle, port 2 SHALL be forwarded first.
REQ-029 The port 1 sop beat SHALL wait (ready=0) until port 2's eop is accepted.

Reset
REQ-030 When reset_n=0, the block SHALL asynchronously force state=IDLE, source_valid=0, source_sop=0, source_eop=0, source_data=0 and err=0.
REQ-031 While reset_n=0, sink_ready and sink_ready2 SHALL be 0.
REQ-032 A reset mid-packet SHALL abandon that packet; the tail beats arriving after reset are dropped per REQ-017.

Configuration
REQ-033 With macro STREAM_PACKET_MUX_ERR_EN defined, err SHALL set on any dropped beat (REQ-017) or any mid-packet sop (REQ-020).
REQ-034 err SHALL stay set until reset.
REQ-035 Without STREAM_PACKET_MUX_ERR_EN, the err port and its logic SHALL be absent, with identical data-path behaviour.

Verification
REQ-036 Port 2 sends 1-beat packet 0x00000F (sop=eop=1), source_ready=1 -> source shows 0x00000F, sop=eop=1 one cycle later; state stays IDLE.
REQ-037 Both ports assert sop the same cycle, port 2 has 3 beats and port 1 has 4 beats -> source carries all 3 port 2 beats, then 4 port 1 beats, with no gap beyond 1 arbitration cycle and no interleave.
REQ-038 Port 1 sends a 100-beat packet while source_ready toggles 1,0,1,0 -> all 100 beats arrive in order with none duplicated or lost, and data is stable while ready=0.
REQ-039 Port 1 drives a beat 0x123456 without sop in IDLE -> sink_ready=1, nothing on source, and err=1 (macro defined).
REQ-040 reset_n pulsed low at beat 5 of a 10-beat packet -> source_valid=0 immediately; the remaining 5 beats are dropped; the next sop packet passes intact.
